d8m_cfg_sequencer: RTL and testbench
====================================

// Module: d8m_cfg_sequencer
// PURPOSE
//  Power-up and register-configuration sequencer for the D8M camera/MIPI bridge.
//  - Drives the sensor reset (oRESET_N) and waits for the sensor to wake.
//  - Walks a register table and issues each write to the I2C master (SCLK/SDATA),
//    one transaction at a time, over a req/ack handshake.
//  - Holds CCD_Capture/RAW2RGB idle (oCFG_DONE low) until configuration succeeds.
// PARAMETERS
//  CLK_HZ      50_000_000  CLK frequency; used to derive all timers
//  RST_LOW_US  1000        oRESET_N low time after start
//  WAKE_US     20000       wait time after oRESET_N rises, before the first I2C access
//  TABLE_LEN   64          number of table entries (1..256)
//  MAX_RETRY   3           extra attempts per entry after a NACK
//  DEV_ADDR    8'h6C       7-bit device address, left-aligned, R/W bit 0
// PORTS
//  CLK        in   1   system clock
//  RST        in   1   asynchronous reset, active-high
//  iSTART     in   1   one-cycle pulse: restart the full sequence (ignored when oBUSY=1)
//  oRESET_N   out  1   sensor reset, active-low
//  oREQ       out  1   I2C transaction request; held until iACK or iNACK
//  oRW        out  1   0 = write, 1 = read
//  oDEV       out  8   device address byte (DEV_ADDR)
//  oREG       out  16  register address
//  oWDATA     out  8   write data
//  iACK       in   1   one-cycle pulse: transaction completed, slave acknowledged
//  iNACK      in   1   one-cycle pulse: transaction completed, slave NACKed
//  iRDATA     in   8   read data; valid in the cycle iACK is high
//  oBUSY      out  1   sequence in progress
//  oCFG_DONE  out  1   table completed without error; sticky until iSTART or RST
//  oERR       out  1   retries exhausted or readback mismatch; sticky until iSTART or RST
//  oERR_IDX   out  8   table index of the first failing entry
// BEHAVIOUR
//  Reset values: oRESET_N=0, oREQ=0, oRW=0, oREG=0, oWDATA=0, oBUSY=1, oCFG_DONE=0,
//   oERR=0, oERR_IDX=0. The sequence starts automatically on RST release.
//  States: RST_LOW -> WAKE -> FETCH -> ISSUE -> WAIT -> [VERIFY] -> NEXT -> ... -> DONE | ERROR.
//  - RST_LOW: oRESET_N=0 for RST_LOW_US*CLK_HZ/1e6 cycles, then oRESET_N=1.
//  - WAKE: waits WAKE_US, then index=0.
//  - FETCH: one-cycle ROM read latency. Entry format {reg[15:0], data[7:0]}.
//    Entry reg==16'hFFFF: delay entry. Waits data ms (0 = no wait), then NEXT; no I2C access.
//  - ISSUE: drives oREQ=1, oRW=0, oREG, oWDATA; these stay stable while oREQ=1.
//  - WAIT: on iACK, oREQ drops in the next cycle and the FSM goes to NEXT.
//    On iNACK, the retry count increments. If retries <= MAX_RETRY, return to ISSUE;
//    otherwise go to ERROR.
//  - If iACK and iNACK arrive together, treat it as NACK.
//  - NEXT: if index==TABLE_LEN-1, go to DONE; otherwise index++, retry count=0, go to FETCH.
//  - DONE: oBUSY=0, oCFG_DONE=1. ERROR: oBUSY=0, oERR=1, oERR_IDX=index.
//    oRESET_N stays 1 in both states.
//  - iSTART in DONE or ERROR: clear the flags, oBUSY=1, go to RST_LOW (full re-run).
//  - iSTART while busy: ignored.
//  - RST mid-sequence: immediate return to reset values. Any open I2C request is
//    abandoned; the I2C master is reset by the same RST.
//  Timers: a single down-counter of $clog2(WAKE_US*CLK_HZ/1e6)+1 bits. The delay
//   counter saturates; it never wraps.
//  Latency: first oREQ rises (RST_LOW_US+WAKE_US)*CLK_HZ/1e6 + 2 cycles after RST release.
// CONFIGURATION
//  D8M_CFG_READBACK_EN defined:
//   - After each write iACK, enter VERIFY: issue oRW=1 to the same oREG.
//   - On iACK, compare iRDATA with data. Mismatch -> ERROR with that index.
//   - A read NACK uses the same retry budget as the write.
//  Not defined: no VERIFY state, oRW is held 0, and iRDATA is ignored.
// STRUCTURE
//  Package d8m_cfg_pkg:
//   - state enum
//   - cfg_entry_t {reg, data}
//   - DELAY_TAG = 16'hFFFF
//   - us-to-cycle conversion function
//  Sub-module d8m_cfg_rom: synchronous table ROM, addr[7:0] -> cfg_entry_t,
//   one-cycle latency, contents from an initial/case table.
//  The FSM, timer, and retry counter stay in d8m_cfg_sequencer.
// TESTING (bench uses CLK_HZ=1_000_000, RST_LOW_US=10, WAKE_US=20, 4-entry table:
//  {3008,01}, {FFFF,02}, {0100,01}, {3500,AA}; I2C master model acks after 5 cycles)
//  1. RST release -> oRESET_N=0 for 10 cycles; first oREQ with oREG=3008, oWDATA=01
//     occurs 32 cycles after release.
//  2. Full run -> three I2C writes; 2000-cycle gap before 0100;
//     oCFG_DONE=1, oBUSY=0 after the 3500 ack.
//  3. Model NACKs 0100 twice, then ACKs -> three requests to 0100, then oCFG_DONE=1, oERR=0.
//  4. Model always NACKs 3500 -> exactly 4 requests, then oERR=1, oERR_IDX=3, oCFG_DONE=0.
//  5. RST asserted while WAIT on entry 2 -> oREQ=0 and oRESET_N=0 the same cycle;
//     iSTART during busy has no effect; iSTART after DONE reruns from RST_LOW.
//  6. With D8M_CFG_READBACK_EN, model returns 55 for 3500 -> read to 3500 issued,
//     then oERR=1, oERR_IDX=3.

Source files
------------

// File: rtl/d8m_cfg_pkg.sv
// Shared types and helpers for the D8M configuration sequencer and its register table.
package d8m_cfg_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_RST_LOW = 4'd0;
   localparam state_t ST_WAKE    = 4'd1;
   localparam state_t ST_FETCH   = 4'd2;
   localparam state_t ST_ISSUE   = 4'd3;
   localparam state_t ST_DELAY   = 4'd4;
   localparam state_t ST_WAIT    = 4'd5;
   localparam state_t ST_VERIFY  = 4'd6;
   localparam state_t ST_NEXT    = 4'd7;
   localparam state_t ST_DONE    = 4'd8;
   localparam state_t ST_ERROR   = 4'd9;

   typedef struct packed {
      logic [15:0] regAddr;
      logic [7:0]  data;
   } cfg_entry_t;

   // A table entry with this register address is a pause of 'data' milliseconds.
   localparam logic [15:0] DELAY_TAG = 16'hFFFF;

   function automatic longint usToCycles(input longint us, input longint clkHz);
      return (us * clkHz) / 64'sd1000000;
   endfunction

endpackage

// File: rtl/d8m_cfg_rom.sv
// Synchronous register-table ROM for the D8M sensor; one cycle from address to entry.
module d8m_cfg_rom
   import d8m_cfg_pkg::*;
(
   input  logic       i_clk,
   input  logic [7:0] i_addr,
   output cfg_entry_t o_entry
);

   // Unused slots are zero-length pauses so a longer TABLE_LEN just walks through them.
   always_ff @(posedge i_clk) begin
      case (i_addr)
         8'd0:    o_entry <= {16'h3008, 8'h01};
         8'd1:    o_entry <= {DELAY_TAG, 8'h02};
         8'd2:    o_entry <= {16'h0100, 8'h01};
         8'd3:    o_entry <= {16'h3500, 8'hAA};
         default: o_entry <= {DELAY_TAG, 8'h00};
      endcase
   end

endmodule

// File: rtl/d8m_cfg_sequencer.sv
// Power-up and I2C register-table sequencer for the D8M camera/MIPI bridge.
// Define D8M_CFG_READBACK_EN to read back and compare every written register.
module d8m_cfg_sequencer
   import d8m_cfg_pkg::*;
#(
   parameter int         CLK_HZ     = 50_000_000,
   parameter int         RST_LOW_US = 1000,
   parameter int         WAKE_US    = 20000,
   parameter int         TABLE_LEN  = 64,
   parameter int         MAX_RETRY  = 3,
   parameter logic [7:0] DEV_ADDR   = 8'h6C
)(
   input  logic        CLK,
   input  logic        RST,
   input  logic        iSTART,
   output logic        oRESET_N,
   output logic        oREQ,
   output logic        oRW,
   output logic [7:0]  oDEV,
   output logic [15:0] oREG,
   output logic [7:0]  oWDATA,
   input  logic        iACK,
   input  logic        iNACK,
   input  logic [7:0]  iRDATA,
   output logic        oBUSY,
   output logic        oCFG_DONE,
   output logic        oERR,
   output logic [7:0]  oERR_IDX
);

   localparam longint RST_CYC  = usToCycles(longint'(RST_LOW_US), longint'(CLK_HZ));
   localparam longint WAKE_CYC = usToCycles(longint'(WAKE_US), longint'(CLK_HZ));
   localparam longint MS_CYC   = usToCycles(64'sd1000, longint'(CLK_HZ));
   localparam longint DLY_CYC  = 64'sd255 * MS_CYC;
   localparam longint SPAN_A   = (RST_CYC > WAKE_CYC) ? RST_CYC : WAKE_CYC;
   // The one timer also serves table pauses, so it must hold the longest one.
   localparam longint TMR_SPAN = (SPAN_A > DLY_CYC) ? SPAN_A : DLY_CYC;
   localparam int     TMR_W    = $clog2(TMR_SPAN) + 1;
   localparam int     RETRY_W  = $clog2(MAX_RETRY + 1) + 1;

   localparam logic [TMR_W-1:0]   TMR_MAX     = '1;
   localparam logic [TMR_W-1:0]   RST_LOAD    = TMR_W'(RST_CYC - 64'sd1);
   localparam logic [TMR_W-1:0]   WAKE_LOAD   = TMR_W'(WAKE_CYC - 64'sd1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
   localparam logic [7:0]         LAST_IDX    = 8'(TABLE_LEN - 1);
   localparam logic [39:0]        MS_CYC_W    = 40'(MS_CYC);

   state_t             r_state;
   logic [TMR_W-1:0]   r_tmr;
   logic [7:0]         r_idx;
   logic [RETRY_W-1:0] r_retry;
   logic               r_resetN;
   logic               r_req;
   logic [15:0]        r_reg;
   logic [7:0]         r_wdata;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [7:0]         r_errIdx;

   cfg_entry_t         w_entry;
   logic               w_tmrZero;
   logic [39:0]        w_delayCycles;
   logic [TMR_W-1:0]   w_delayLoad;

   d8m_cfg_rom u_rom (
      .i_clk   (CLK),
      .i_addr  (r_idx),
      .o_entry (w_entry)
   );

   assign w_tmrZero     = (r_tmr == '0);
   assign w_delayCycles = 40'(w_entry.data) * MS_CYC_W;
   assign w_delayLoad   = ((w_delayCycles - 40'd1) > 40'(TMR_MAX)) ? TMR_MAX
                        : (w_delayCycles[TMR_W-1:0] - TMR_W'(1));

`ifdef D8M_CFG_READBACK_EN
   logic r_rw;
   assign oRW = r_rw;
`else
   logic w_unusedRdata;
   assign w_unusedRdata = ^iRDATA;
   assign oRW           = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= ST_RST_LOW;
         r_tmr    <= RST_LOAD;
         r_idx    <= 8'd0;
         r_retry  <= '0;
         r_resetN <= 1'b0;
         r_req    <= 1'b0;
         r_reg    <= 16'h0000;
         r_wdata  <= 8'h00;
         r_busy   <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_errIdx <= 8'd0;
`ifdef D8M_CFG_READBACK_EN
         r_rw     <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_RST_LOW: begin
               if (w_tmrZero) begin
                  r_resetN <= 1'b1;
                  r_tmr    <= WAKE_LOAD;
                  r_state  <= ST_WAKE;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            ST_WAKE: begin
               if (w_tmrZero) begin
                  r_idx   <= 8'd0;
                  r_retry <= '0;
                  r_state <= ST_FETCH;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            ST_FETCH: begin
               r_state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (w_entry.regAddr == DELAY_TAG) begin
                  if (w_entry.data == 8'h00) begin
                     r_state <= ST_NEXT;
                  end else begin
                     r_tmr   <= w_delayLoad;
                     r_state <= ST_DELAY;
                  end
               end else begin
                  r_req   <= 1'b1;
                  r_reg   <= w_entry.regAddr;
                  r_wdata <= w_entry.data;
                  r_state <= ST_WAIT;
`ifdef D8M_CFG_READBACK_EN
                  r_rw    <= 1'b0;
`endif
               end
            end
            ST_DELAY: begin
               if (w_tmrZero) begin
                  r_state <= ST_NEXT;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            // A simultaneous ACK and NACK is taken as a NACK.
            ST_WAIT: begin
               if (iNACK) begin
                  r_req <= 1'b0;
                  if (r_retry == RETRY_LIMIT) begin
                     r_state  <= ST_ERROR;
                     r_busy   <= 1'b0;
                     r_err    <= 1'b1;
                     r_errIdx <= r_idx;
                  end else begin
                     r_retry <= r_retry + RETRY_W'(1);
`ifdef D8M_CFG_READBACK_EN
                     r_state <= r_rw ? ST_VERIFY : ST_ISSUE;
`else
                     r_state <= ST_ISSUE;
`endif
                  end
               end else if (iACK) begin
                  r_req <= 1'b0;
`ifdef D8M_CFG_READBACK_EN
                  if (!r_rw) begin
                     r_state <= ST_VERIFY;
                  end else if (iRDATA != r_wdata) begin
                     r_state  <= ST_ERROR;
                     r_busy   <= 1'b0;
                     r_err    <= 1'b1;
                     r_errIdx <= r_idx;
                  end else begin
                     r_state <= ST_NEXT;
                  end
`else
                  r_state <= ST_NEXT;
`endif
               end
            end
`ifdef D8M_CFG_READBACK_EN
            ST_VERIFY: begin
               r_req   <= 1'b1;
               r_rw    <= 1'b1;
               r_state <= ST_WAIT;
            end
`endif
            ST_NEXT: begin
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx   <= r_idx + 8'd1;
                  r_retry <= '0;
                  r_state <= ST_FETCH;
               end
            end
            // A restart repeats the whole power-up, including the sensor reset pulse.
            ST_DONE, ST_ERROR: begin
               if (iSTART) begin
                  r_state  <= ST_RST_LOW;
                  r_tmr    <= RST_LOAD;
                  r_resetN <= 1'b0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_err    <= 1'b0;
                  r_errIdx <= 8'd0;
                  r_idx    <= 8'd0;
                  r_retry  <= '0;
               end
            end
            default: begin
               r_state  <= ST_RST_LOW;
               r_tmr    <= RST_LOAD;
               r_resetN <= 1'b0;
               r_req    <= 1'b0;
               r_busy   <= 1'b1;
            end
         endcase
      end
   end

   assign oRESET_N  = r_resetN;
   assign oREQ      = r_req;
   assign oDEV      = DEV_ADDR;
   assign oREG      = r_reg;
   assign oWDATA    = r_wdata;
   assign oBUSY     = r_busy;
   assign oCFG_DONE = r_done;
   assign oERR      = r_err;
   assign oERR_IDX  = r_errIdx;

endmodule

// File: tb/tb_d8m_cfg_sequencer.sv
// Directed bench for d8m_cfg_sequencer with a small I2C master model that answers after 5 cycles.
// The readback scenario only runs when D8M_CFG_READBACK_EN is defined.
module tb_d8m_cfg_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iSTART = 1'b0;
   logic        iACK = 1'b0;
   logic        iNACK = 1'b0;
   logic [7:0]  iRDATA = 8'h00;
   logic        oRESET_N, oREQ, oRW, oBUSY, oCFG_DONE, oERR;
   logic [7:0]  oDEV, oWDATA, oERR_IDX;
   logic [15:0] oREG;

   int cyc = 0;
   int passCount = 0;
   int checkCount = 0;
   int mode = 0;

   int n3008 = 0, n0100 = 0, n3500 = 0, nWrites = 0, nReads3500 = 0;
   int rise3008Cyc = 0, lastFallCyc = 0, gap0100 = 0;
   logic [15:0] firstReg = 16'h0000;
   logic [7:0]  firstData = 8'h00;
   logic        rwSeen = 1'b0;

   int b3008, b0100, b3500, bWrites, bReads3500;
   int relCyc;

   d8m_cfg_sequencer #(
      .CLK_HZ     (1_000_000),
      .RST_LOW_US (10),
      .WAKE_US    (20),
      .TABLE_LEN  (4),
      .MAX_RETRY  (3),
      .DEV_ADDR   (8'h6C)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .iSTART    (iSTART),
      .oRESET_N  (oRESET_N),
      .oREQ      (oREQ),
      .oRW       (oRW),
      .oDEV      (oDEV),
      .oREG      (oREG),
      .oWDATA    (oWDATA),
      .iACK      (iACK),
      .iNACK     (iNACK),
      .iRDATA    (iRDATA),
      .oBUSY     (oBUSY),
      .oCFG_DONE (oCFG_DONE),
      .oERR      (oERR),
      .oERR_IDX  (oERR_IDX)
   );

   always #5 CLK = ~CLK;

   // Edge counter: at the negedge after posedge k it reads k.
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [7:0] readValue(input logic [15:0] regAddr, input int curMode);
      case (regAddr)
         16'h3008: return 8'h01;
         16'h0100: return 8'h01;
         16'h3500: return (curMode == 3) ? 8'h55 : 8'hAA;
         default:  return 8'h00;
      endcase
   endfunction

   // I2C master model: answers every request on its 5th sampled cycle and logs traffic.
   initial begin : i2cModel
      int   age;
      logic prevReq;
      logic doNack;
      age = 0;
      prevReq = 1'b0;
      forever begin
         @(negedge CLK);
         iACK = 1'b0;
         iNACK = 1'b0;
         if (RST) begin
            age = 0;
            prevReq = 1'b0;
         end else begin
            if (oRW) rwSeen = 1'b1;
            if (oREQ && !prevReq) begin
               if (!oRW) begin
                  nWrites++;
                  if (nWrites == 1) begin
                     firstReg = oREG;
                     firstData = oWDATA;
                  end
                  case (oREG)
                     16'h3008: begin
                        n3008++;
                        rise3008Cyc = cyc;
                     end
                     16'h0100: begin
                        n0100++;
                        gap0100 = cyc - lastFallCyc;
                     end
                     16'h3500: n3500++;
                     default: ;
                  endcase
               end else if (oREG == 16'h3500) begin
                  nReads3500++;
               end
            end
            if (!oREQ && prevReq) lastFallCyc = cyc;
            prevReq = oREQ;
            if (oREQ) begin
               age++;
               if (age == 5) begin
                  age = 0;
                  doNack = (!oRW && mode == 1 && oREG == 16'h0100 && (n0100 - b0100) <= 2)
                        || (!oRW && mode == 2 && oREG == 16'h3500);
                  if (doNack) begin
                     iNACK = 1'b1;
                  end else begin
                     iACK = 1'b1;
                     iRDATA = oRW ? readValue(oREG, mode) : 8'h00;
                  end
               end
            end else begin
               age = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // One-cycle iSTART pulse, driven from a negedge.
   task automatic applyStimulus();
      iSTART = 1'b1;
      @(negedge CLK);
      iSTART = 1'b0;
   endtask

   task automatic takeSnapshot();
      b3008 = n3008;
      b0100 = n0100;
      b3500 = n3500;
      bWrites = nWrites;
      bReads3500 = nReads3500;
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n;
      n = 0;
      while (oBUSY && n < budget) begin
         @(negedge CLK);
         n++;
      end
      checkOutput(tag, 32'(oBUSY), 32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int n;
      RST = 1'b1;
      repeat (3) @(negedge CLK);

      checkOutput("rst_resetN", 32'(oRESET_N), 32'd0);
      checkOutput("rst_req", 32'(oREQ), 32'd0);
      checkOutput("rst_rw", 32'(oRW), 32'd0);
      checkOutput("rst_reg", 32'(oREG), 32'h0);
      checkOutput("rst_wdata", 32'(oWDATA), 32'h0);
      checkOutput("rst_busy", 32'(oBUSY), 32'd1);
      checkOutput("rst_done", 32'(oCFG_DONE), 32'd0);
      checkOutput("rst_err", 32'(oERR), 32'd0);
      checkOutput("rst_erridx", 32'(oERR_IDX), 32'd0);
      checkOutput("rst_dev", 32'(oDEV), 32'h6C);

      // Run 1: plain power-up and full table.
      mode = 0;
      takeSnapshot();
      RST = 1'b0;
      relCyc = cyc;
      repeat (9) @(negedge CLK);
      checkOutput("run1_resetN_low", 32'(oRESET_N), 32'd0);
      @(negedge CLK);
      checkOutput("run1_resetN_high", 32'(oRESET_N), 32'd1);
      repeat (5) @(negedge CLK);
      applyStimulus();
      checkOutput("busy_start_ignored_busy", 32'(oBUSY), 32'd1);
      checkOutput("busy_start_ignored_resetN", 32'(oRESET_N), 32'd1);
      waitIdle("run1_idle", 5000);
      checkOutput("run1_first_req_latency", 32'(rise3008Cyc - relCyc), 32'd32);
      checkOutput("run1_first_reg", 32'(firstReg), 32'h3008);
      checkOutput("run1_first_wdata", 32'(firstData), 32'h01);
      checkOutput("run1_writes", 32'(nWrites - bWrites), 32'd3);
      checkOutput("run1_writes_0100", 32'(n0100 - b0100), 32'd1);
      // 2 ms pause (2000 cycles) plus NEXT/FETCH/ISSUE around it and the NEXT/FETCH/ISSUE to reach 0100.
      checkOutput("run1_gap_0100", 32'(gap0100), 32'd2006);
      checkOutput("run1_done", 32'(oCFG_DONE), 32'd1);
      checkOutput("run1_err", 32'(oERR), 32'd0);
      checkOutput("run1_resetN_done", 32'(oRESET_N), 32'd1);

      // Run 2: restart from DONE, 0100 NACKed twice then accepted.
      mode = 1;
      takeSnapshot();
      relCyc = cyc;
      applyStimulus();
      checkOutput("run2_busy", 32'(oBUSY), 32'd1);
      checkOutput("run2_done_cleared", 32'(oCFG_DONE), 32'd0);
      checkOutput("run2_resetN_low", 32'(oRESET_N), 32'd0);
      repeat (9) @(negedge CLK);
      checkOutput("run2_resetN_still_low", 32'(oRESET_N), 32'd0);
      @(negedge CLK);
      checkOutput("run2_resetN_high", 32'(oRESET_N), 32'd1);
      waitIdle("run2_idle", 5000);
      checkOutput("run2_first_req_latency", 32'(rise3008Cyc - relCyc), 32'd33);
      checkOutput("run2_writes_0100", 32'(n0100 - b0100), 32'd3);
      checkOutput("run2_writes_3008", 32'(n3008 - b3008), 32'd1);
      checkOutput("run2_writes_3500", 32'(n3500 - b3500), 32'd1);
      checkOutput("run2_done", 32'(oCFG_DONE), 32'd1);
      checkOutput("run2_err", 32'(oERR), 32'd0);

      // Run 3: 3500 always NACKed, retries run out.
      mode = 2;
      takeSnapshot();
      applyStimulus();
      waitIdle("run3_idle", 5000);
      checkOutput("run3_writes_3500", 32'(n3500 - b3500), 32'd4);
      checkOutput("run3_err", 32'(oERR), 32'd1);
      checkOutput("run3_erridx", 32'(oERR_IDX), 32'd3);
      checkOutput("run3_done", 32'(oCFG_DONE), 32'd0);
      checkOutput("run3_resetN", 32'(oRESET_N), 32'd1);

      // Run 4: restart from ERROR, then assert RST while waiting on entry 2.
      mode = 0;
      takeSnapshot();
      applyStimulus();
      checkOutput("run4_err_cleared", 32'(oERR), 32'd0);
      checkOutput("run4_erridx_cleared", 32'(oERR_IDX), 32'd0);
      n = 0;
      while (!(oREQ && !oRW && oREG == 16'h0100) && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      checkOutput("run4_reached_entry2", 32'(oREQ), 32'd1);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      #1;
      checkOutput("midrst_req", 32'(oREQ), 32'd0);
      checkOutput("midrst_resetN", 32'(oRESET_N), 32'd0);
      checkOutput("midrst_busy", 32'(oBUSY), 32'd1);
      @(negedge CLK);
      takeSnapshot();
      RST = 1'b0;
      relCyc = cyc;
      waitIdle("run5_idle", 5000);
      checkOutput("run5_first_req_latency", 32'(rise3008Cyc - relCyc), 32'd32);
      checkOutput("run5_writes", 32'(nWrites - bWrites), 32'd3);
      checkOutput("run5_done", 32'(oCFG_DONE), 32'd1);

`ifdef D8M_CFG_READBACK_EN
      // Run 6: readback of 3500 returns 0x55 instead of 0xAA.
      mode = 3;
      takeSnapshot();
      applyStimulus();
      waitIdle("run6_idle", 5000);
      checkOutput("run6_reads_3500", 32'(nReads3500 - bReads3500), 32'd1);
      checkOutput("run6_err", 32'(oERR), 32'd1);
      checkOutput("run6_erridx", 32'(oERR_IDX), 32'd3);
      checkOutput("run6_done", 32'(oCFG_DONE), 32'd0);
`else
      checkOutput("no_read_issued", 32'(rwSeen), 32'd0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
